// File: rtl/ddr3_emif_arbiter.sv
// Round-robin burst scheduler sharing one DDR3 EMIF Avalon-MM port between a
// burst-write requester and a burst-read requester, with read-beat credit tracking.
module ddr3_emif_arbiter #(
  parameter int MAX_BURST    = 16,
  parameter int MAX_RD_BEATS = 32
) (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst_n,
  input  logic         wr_cmd_valid,
  input  logic [24:0]  wr_cmd_addr,
  input  logic [4:0]   wr_cmd_len,
  output logic         wr_cmd_ready,
  input  logic [255:0] wr_data,
  output logic         wr_data_ack,
  input  logic         rd_cmd_valid,
  input  logic [24:0]  rd_cmd_addr,
  input  logic [4:0]   rd_cmd_len,
  output logic         rd_cmd_ready,
  output logic [255:0] rd_data,
  output logic         rd_data_valid,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_read,
  output logic         ddr3_emif_write,
  output logic [24:0]  ddr3_emif_addr,
  output logic [4:0]   ddr3_emif_burst_count,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  input  logic [255:0] ddr3_emif_read_data,
  input  logic         ddr3_emif_rddata_valid,
  output logic [5:0]   rd_outstanding,
  output logic         busy,
  output logic         err_rdata
);

  localparam logic [4:0] MAX_LEN    = 5'(MAX_BURST);
  localparam logic [6:0] RD_CREDITS = 7'(MAX_RD_BEATS);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD} state_e;

  state_e      state_q;
  logic        write_q, read_q;
  logic        wr_rdy_q, rd_rdy_q;
  logic        last_rd_q;
  logic        err_q, err_d;
  logic [24:0] addr_q;
  logic [4:0]  len_q, beat_q;
  logic [5:0]  rd_out_q, rd_out_d;

  logic [4:0]  wr_len, rd_len;
  logic        rd_elig, grant_wr, grant_rd, rd_acc, wr_beat;

  function automatic logic [4:0] eff_len(input logic [4:0] len);
    if (len == 5'd0)  return 5'd1;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  assign wr_len  = eff_len(wr_cmd_len);
  assign rd_len  = eff_len(rd_cmd_len);
  assign rd_elig = rd_cmd_valid && (({2'b00, rd_len} + {1'b0, rd_out_q}) <= RD_CREDITS);

  // An ineligible read never competes, so it cannot hold off a write.
  assign grant_wr = wr_cmd_valid && (!rd_elig || last_rd_q);
  assign grant_rd = rd_elig && (!wr_cmd_valid || !last_rd_q);

  assign rd_acc  = read_q && ddr3_emif_ready;
  assign wr_beat = write_q && ddr3_emif_ready;

  // Return beats with nothing outstanding are flagged rather than underflowing the credit count.
  assign rd_out_d = rd_out_q
                  + (rd_acc ? {1'b0, len_q} : 6'd0)
                  - ((ddr3_emif_rddata_valid && (rd_out_q != 6'd0)) ? 6'd1 : 6'd0);
  assign err_d    = err_q | (ddr3_emif_rddata_valid && (rd_out_q == 6'd0));

  always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
    if (!ddr3_emif_rst_n) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wr_rdy_q  <= 1'b0;
      rd_rdy_q  <= 1'b0;
      last_rd_q <= 1'b1;
      err_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      rd_out_q  <= '0;
    end else begin
      wr_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      rd_out_q <= rd_out_d;
      err_q    <= err_d;
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q   <= WR_BURST;
            write_q   <= 1'b1;
            addr_q    <= wr_cmd_addr;
            len_q     <= wr_len;
            beat_q    <= '0;
            wr_rdy_q  <= 1'b1;
            last_rd_q <= 1'b0;
          end else if (grant_rd) begin
            state_q   <= RD_CMD;
            read_q    <= 1'b1;
            addr_q    <= rd_cmd_addr;
            len_q     <= rd_len;
            rd_rdy_q  <= 1'b1;
            last_rd_q <= 1'b1;
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            beat_q <= beat_q + 5'd1;
            if (beat_q + 5'd1 == len_q) begin
              write_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        RD_CMD: begin
          if (ddr3_emif_ready) begin
            read_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_cmd_ready          = wr_rdy_q;
  assign rd_cmd_ready          = rd_rdy_q;
  assign wr_data_ack           = wr_beat;
  assign ddr3_emif_write       = write_q;
  assign ddr3_emif_read        = read_q;
  assign ddr3_emif_addr        = addr_q;
  assign ddr3_emif_burst_count = len_q;
  assign ddr3_emif_write_data  = wr_data;
  assign ddr3_emif_byte_enable = {32{1'b1}};
  assign rd_data               = ddr3_emif_read_data;
  assign rd_data_valid         = ddr3_emif_rddata_valid;
  assign rd_outstanding        = rd_out_q;
  assign busy                  = (state_q != IDLE);
  assign err_rdata             = err_q;

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Randomized bench for ddr3_emif_arbiter: requester/memory models drive the DUT and a
// transaction-level model predicts grants, burst shapes and read credits.
module tb_ddr3_emif_arbiter;

  localparam int MAXB  = 16;
  localparam int MAXRD = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wr_cmd_valid, rd_cmd_valid;
  logic [24:0]  wr_cmd_addr, rd_cmd_addr;
  logic [4:0]   wr_cmd_len, rd_cmd_len;
  logic         wr_cmd_ready, rd_cmd_ready;
  logic [255:0] wr_data, rd_data;
  logic         wr_data_ack, rd_data_valid;
  logic         emif_ready, emif_read, emif_write;
  logic [24:0]  emif_addr;
  logic [4:0]   emif_bc;
  logic [255:0] emif_wdata, emif_rdata;
  logic [31:0]  emif_be;
  logic         emif_rvalid;
  logic [5:0]   rd_outstanding;
  logic         busy, err_rdata;

  ddr3_emif_arbiter #(.MAX_BURST(MAXB), .MAX_RD_BEATS(MAXRD)) dut (
    .ddr3_emif_clk(clk), .ddr3_emif_rst_n(rst_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .wr_cmd_ready(wr_cmd_ready), .wr_data(wr_data), .wr_data_ack(wr_data_ack),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .rd_cmd_ready(rd_cmd_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .ddr3_emif_ready(emif_ready), .ddr3_emif_read(emif_read), .ddr3_emif_write(emif_write),
    .ddr3_emif_addr(emif_addr), .ddr3_emif_burst_count(emif_bc),
    .ddr3_emif_write_data(emif_wdata), .ddr3_emif_byte_enable(emif_be),
    .ddr3_emif_read_data(emif_rdata), .ddr3_emif_rddata_valid(emif_rvalid),
    .rd_outstanding(rd_outstanding), .busy(busy), .err_rdata(err_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [24:0] addr; int len;} cmd_t;
  cmd_t wq[$], rq[$];
  cmd_t wr_exp, rd_exp;
  int   glog[$];

  int checks = 0, failures = 0;
  int mdl_out, mem_pend, ret_allow, ready_mode, stall_at, stall_left;
  int burst_acks, last_burst_acks, wr_rem, wr_grants, rd_issued, wr_hi;
  int last_wr_bc, last_rd_bc, p_rl, p_out;
  bit mdl_err, mdl_last_rd, rd_wait, wr_pop, rd_pop, ack_seen, inject_rv, rv_random;
  bit p_idle, p_wv, p_rv;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int eff_len(input int n);
    if (n == 0) return 1;
    if (n > MAXB) return MAXB;
    return n;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic monitor();
    int  g_exp, g_got, acc_l;
    bit  we, re;
    check_eq("rd_data", rd_data, emif_rdata);
    check_eq("rd_dv", rd_data_valid, emif_rvalid);
    check_eq("wdata", emif_wdata, wr_data);
    check_eq("byte_en", emif_be, {32{1'b1}});
    check_eq("overlap", emif_read & emif_write, 1'b0);
    check_eq("busy", busy, emif_read | emif_write);
    check_eq("ack", wr_data_ack, emif_write & emif_ready);
    check_eq("rd_out", rd_outstanding, mdl_out);
    check_eq("err", err_rdata, mdl_err);

    // Arbitration decided in the previous (idle) cycle shows up as a cmd_ready now.
    g_exp = 0;
    if (p_idle) begin
      we = p_wv;
      re = p_rv && (p_out + p_rl <= MAXRD);
      if (we && re)  g_exp = mdl_last_rd ? 1 : 2;
      else if (we)   g_exp = 1;
      else if (re)   g_exp = 2;
    end
    g_got = (wr_cmd_ready ? 1 : 0) + (rd_cmd_ready ? 2 : 0);
    check_eq("grant", g_got, g_exp);

    if (wr_cmd_ready && wq.size() > 0) begin
      wr_exp = wq[0];
      wr_exp.len = eff_len(wr_exp.len);
      wr_rem = wr_exp.len;
      burst_acks = 0;
      wr_pop = 1;
      wr_grants++;
      mdl_last_rd = 0;
      glog.push_back(1);
      last_wr_bc = emif_bc;
      check_eq("wr_lat", emif_write, 1'b1);
    end
    if (rd_cmd_ready && rq.size() > 0) begin
      rd_exp = rq[0];
      rd_exp.len = eff_len(rd_exp.len);
      rd_wait = 1;
      rd_pop = 1;
      mdl_last_rd = 1;
      glog.push_back(2);
      last_rd_bc = emif_bc;
      check_eq("rd_lat", emif_read, 1'b1);
    end

    if (emif_write) begin
      check_eq("wr_extra", wr_rem > 0, 1'b1);
      if (wr_rem > 0) begin
        check_eq("wr_addr", emif_addr, wr_exp.addr);
        check_eq("wr_bc", emif_bc, wr_exp.len);
        wr_hi++;
        if (emif_ready) begin
          wr_rem--;
          burst_acks++;
          ack_seen = 1;
          if (wr_rem == 0) last_burst_acks = burst_acks;
        end
      end
    end else begin
      check_eq("wr_short", wr_rem, 0);
      wr_rem = 0;
    end

    acc_l = 0;
    if (emif_read) begin
      check_eq("rd_extra", rd_wait, 1'b1);
      if (rd_wait) begin
        check_eq("rd_addr", emif_addr, rd_exp.addr);
        check_eq("rd_bc", emif_bc, rd_exp.len);
        if (emif_ready) begin
          acc_l = rd_exp.len;
          rd_wait = 0;
          rd_issued++;
          mem_pend += acc_l;
        end
      end
    end else begin
      check_eq("rd_drop", rd_wait, 1'b0);
      rd_wait = 0;
    end

    p_idle = !emif_read && !emif_write;
    p_wv   = wr_cmd_valid;
    p_rv   = rd_cmd_valid;
    p_rl   = eff_len(int'(rd_cmd_len));
    p_out  = mdl_out;
    if (emif_rvalid) begin
      if (mdl_out == 0) mdl_err = 1;
      else mdl_out--;
    end
    mdl_out += acc_l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_pop && wq.size() > 0) void'(wq.pop_front());
    if (rd_pop && rq.size() > 0) void'(rq.pop_front());
    wr_pop = 0;
    rd_pop = 0;
    wr_cmd_valid = (wq.size() > 0);
    wr_cmd_addr  = (wq.size() > 0) ? wq[0].addr : 25'd0;
    wr_cmd_len   = (wq.size() > 0) ? 5'(wq[0].len) : 5'd0;
    rd_cmd_valid = (rq.size() > 0);
    rd_cmd_addr  = (rq.size() > 0) ? rq[0].addr : 25'd0;
    rd_cmd_len   = (rq.size() > 0) ? 5'(rq[0].len) : 5'd0;
    if (ack_seen) wr_data = rand256();
    ack_seen = 0;
    emif_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (stall_left > 0 && emif_write && burst_acks == stall_at) begin
      emif_ready = 1'b0;
      stall_left--;
    end
    emif_rdata = rand256();
    if (inject_rv) begin
      emif_rvalid = 1'b1;
      inject_rv = 0;
    end else if (mem_pend > 0 && ret_allow > 0 && (!rv_random || $urandom_range(0, 1) == 1)) begin
      emif_rvalid = 1'b1;
      mem_pend--;
      ret_allow--;
    end else begin
      emif_rvalid = 1'b0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_write", emif_write, 1'b0);
    check_eq("rst_read", emif_read, 1'b0);
    check_eq("rst_addr", emif_addr, 25'd0);
    check_eq("rst_bc", emif_bc, 5'd0);
    check_eq("rst_wrdy", wr_cmd_ready, 1'b0);
    check_eq("rst_rrdy", rd_cmd_ready, 1'b0);
    check_eq("rst_out", rd_outstanding, 6'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err_rdata, 1'b0);
    check_eq("rst_ack", wr_data_ack, 1'b0);
    wq.delete();
    rq.delete();
    wr_cmd_valid = 0; rd_cmd_valid = 0; emif_rvalid = 0; emif_ready = 1;
    wr_cmd_addr = 0; rd_cmd_addr = 0; wr_cmd_len = 0; rd_cmd_len = 0;
    mdl_out = 0; mdl_err = 0; mdl_last_rd = 1; mem_pend = 0;
    wr_rem = 0; rd_wait = 0; wr_pop = 0; rd_pop = 0; ack_seen = 0; inject_rv = 0;
    stall_left = 0; burst_acks = 0; wr_grants = 0; rd_issued = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p_idle = 1; p_wv = 0; p_rv = 0; p_rl = 1; p_out = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    bit done;
    n = 0;
    while ((wq.size() > 0 || rq.size() > 0 || wr_rem > 0 || rd_wait || mem_pend > 0 ||
            wr_pop || rd_pop) && n < max_cycles) begin
      tick();
      n++;
    end
    done = (n < max_cycles);
    check_eq("drain_timeout", done, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, h0;
    wr_data = rand256(); emif_rdata = '0;
    wr_cmd_valid = 0; rd_cmd_valid = 0; emif_rvalid = 0; emif_ready = 1;
    wr_cmd_addr = 0; rd_cmd_addr = 0; wr_cmd_len = 0; rd_cmd_len = 0;
    ret_allow = 1000000; ready_mode = 0; rv_random = 0; stall_at = 0; wr_hi = 0;
    last_burst_acks = 0; last_wr_bc = 0; last_rd_bc = 0;
    #1 do_reset();

    // Single write
    g0 = wr_grants; h0 = wr_hi;
    wq.push_back('{addr: 25'h100, len: 4});
    drain(50);
    check_eq("sw_grants", wr_grants - g0, 1);
    check_eq("sw_write_cycles", wr_hi - h0, 4);
    check_eq("sw_acks", last_burst_acks, 4);
    check_eq("sw_bc", last_wr_bc, 4);

    // Contention after reset
    #2 do_reset();
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{addr: 25'($urandom()), len: 2});
      rq.push_back('{addr: 25'($urandom()), len: 2});
    end
    drain(200);
    check_eq("cont_n", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check_eq("cont_order", glog[i], (i % 2 == 0) ? 1 : 2);

    // Credit limit with a write slipping past the blocked read
    #2 do_reset();
    ret_allow = 0;
    for (int i = 0; i < 9; i++) rq.push_back('{addr: 25'($urandom()), len: 4});
    repeat (40) tick();
    check_eq("cr_issued", rd_issued, 8);
    check_eq("cr_out", rd_outstanding, 6'd32);
    check_eq("cr_held", rq.size(), 1);
    wq.push_back('{addr: 25'($urandom()), len: 3});
    repeat (12) tick();
    check_eq("cr_wr_pass", wr_grants, 1);
    check_eq("cr_still_held", rd_issued, 8);
    ret_allow = 4;
    repeat (15) tick();
    check_eq("cr_ninth", rd_issued, 9);
    ret_allow = 1000000;
    drain(200);

    // Backpressure in beat 2
    h0 = wr_hi; burst_acks = 0; stall_at = 1; stall_left = 3;
    wq.push_back('{addr: 25'h0ABCDE, len: 4});
    drain(50);
    check_eq("bp_acks", last_burst_acks, 4);
    check_eq("bp_stall_used", stall_left, 0);
    check_eq("bp_write_cycles", wr_hi - h0, 7);

    // Length clamp
    wq.push_back('{addr: 25'($urandom()), len: 0});
    rq.push_back('{addr: 25'($urandom()), len: 20});
    drain(100);
    check_eq("clamp_w", last_wr_bc, 1);
    check_eq("clamp_r", last_rd_bc, 16);

    // Random traffic
    ready_mode = 1; rv_random = 1;
    repeat (1500) begin
      if (wq.size() < 2 && $urandom_range(0, 3) == 0)
        wq.push_back('{addr: 25'($urandom()), len: int'($urandom_range(0, 31))});
      if (rq.size() < 2 && $urandom_range(0, 3) == 0)
        rq.push_back('{addr: 25'($urandom()), len: int'($urandom_range(0, 31))});
      tick();
    end
    drain(1000);
    ready_mode = 0; rv_random = 0;
    check_eq("rnd_out_zero", rd_outstanding, 6'd0);

    // Stray read data
    inject_rv = 1;
    tick();
    repeat (3) tick();
    check_eq("err_set", err_rdata, 1'b1);
    wq.push_back('{addr: 25'($urandom()), len: 2});
    drain(50);
    check_eq("err_sticky", err_rdata, 1'b1);

    // Reset in the middle of a write burst with reads outstanding
    ret_allow = 0;
    rq.push_back('{addr: 25'($urandom()), len: 8});
    repeat (4) tick();
    wq.push_back('{addr: 25'($urandom()), len: 16});
    repeat (5) tick();
    check_eq("mid_out", rd_outstanding, 6'd8);
    check_eq("mid_write", emif_write, 1'b1);
    #2 do_reset();
    ret_allow = 1000000;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr3_emif_arbiter.md
# ddr3_emif_arbiter

Two-port scheduler that shares the single DDR3 EMIF Avalon-MM port between the capture path (burst writes) and the video pattern generator frame fetch (burst reads). It sits between those requesters and the DDR3 controller, entirely in the `ddr3_emif_clk` domain. It grants whole bursts round-robin and tracks outstanding read beats against a credit limit. Read data and write data pass straight through.

## Interface
- `MAX_BURST`, 16: largest burst issued; `cmd_len` is clamped to this value.
- `MAX_RD_BEATS`, 32: maximum read beats outstanding at the EMIF.
- `ddr3_emif_clk` in 1: single clock.
- `ddr3_emif_rst_n` in 1: reset, asynchronous, active-low.
- `wr_cmd_valid` in 1: write burst request.
- `wr_cmd_addr` in 25: write burst word address.
- `wr_cmd_len` in 5: write burst beat count.
- `wr_cmd_ready` out 1: one-cycle pulse when the write command is latched.
- `wr_data` in 256: current write beat, from a show-ahead FIFO.
- `wr_data_ack` out 1: beat accepted by the EMIF; the requester advances to the next beat.
- `rd_cmd_valid` in 1: read burst request.
- `rd_cmd_addr` in 25: read burst word address.
- `rd_cmd_len` in 5: read burst beat count.
- `rd_cmd_ready` out 1: one-cycle pulse when the read command is latched.
- `rd_data` out 256: equals `ddr3_emif_read_data`.
- `rd_data_valid` out 1: equals `ddr3_emif_rddata_valid`.
- `ddr3_emif_ready` in 1: EMIF accepts the current command or beat (inverse of waitrequest).
- `ddr3_emif_read` out 1: Avalon read.
- `ddr3_emif_write` out 1: Avalon write.
- `ddr3_emif_addr` out 25: Avalon address.
- `ddr3_emif_burst_count` out 5: Avalon burst count.
- `ddr3_emif_write_data` out 256: equals `wr_data`.
- `ddr3_emif_byte_enable` out 32: constant all-ones.
- `ddr3_emif_read_data` in 256: Avalon read data.
- `ddr3_emif_rddata_valid` in 1: Avalon read data valid.
- `rd_outstanding` out 6: read beats issued but not yet returned.
- `busy` out 1: state is not IDLE.
- `err_rdata` out 1: sticky flag, set when `ddr3_emif_rddata_valid` arrives with `rd_outstanding` = 0.

## Operation
- **States:** IDLE, WR_BURST, RD_CMD. Reset puts the block in IDLE with these values:
  - `read`, `write`, `cmd_ready` pulses, `addr`, `burst_count` all 0.
  - `rd_outstanding` = 0, `err_rdata` = 0.
  - `last_grant` = read, so the first contention goes to write.
- **Length rule:** effective length L = 1 when `cmd_len` = 0, MAX_BURST when `cmd_len` > MAX_BURST, otherwise `cmd_len`.
- **Read eligibility:** a read is eligible when `rd_cmd_valid` is high and `rd_outstanding` + L_rd <= MAX_RD_BEATS.
- **IDLE arbitration:**
  - Only writes pending → grant write.
  - Only an eligible read pending → grant read.
  - Both pending → grant the port opposite to `last_grant`.
  - A pending read that is not eligible never blocks a write.
  - On grant, register `addr`, L, the port's `cmd_ready` pulse and `last_grant`.
- **WR_BURST:**
  - `ddr3_emif_write` = 1; `addr` and `burst_count` are held for the whole burst.
  - Each cycle with `ddr3_emif_write` & `ddr3_emif_ready`: `wr_data_ack` = 1 (combinational) and the beat counter increments.
  - After L accepted beats, `write` drops on the next edge and the state returns to IDLE.
  - The requester must have all L beats available in its FIFO before raising `wr_cmd_valid`.
- **RD_CMD:**
  - `ddr3_emif_read` = 1, held until `ddr3_emif_ready`.
  - On acceptance: `rd_outstanding` += L, state returns to IDLE, and `read` drops on the next edge.
- **Credit update:** each `ddr3_emif_rddata_valid` beat decrements `rd_outstanding`. On the same edge as a read acceptance, the net change is L − 1.
- **`ddr3_emif_ready` low:** the current command or beat holds unchanged, indefinitely.
- **Reset mid-burst:** outputs go to their reset values immediately. The partial burst is abandoned; the system-level reset must also reset the requesters' FIFOs.

## Timing
- **Command latency:** `cmd_valid` sampled in IDLE at cycle N. At N+1:
  - `ddr3_emif_read` or `ddr3_emif_write` is 1.
  - `cmd_ready` pulses for exactly one cycle.
  - The requester drops or changes `cmd_valid` from N+2.
- **Write burst, `ready` constantly 1:** `write` is high in cycles N+1 .. N+L, IDLE at N+L+1, next grant visible at N+L+2.
- **Read, `ready` = 1:** `read` is high for one cycle at N+1. Back-to-back reads issue every 2 cycles.
- **Pass-through paths:** `rd_data`, `rd_data_valid` and `ddr3_emif_write_data` have zero latency.
- **Clean handover:** `read` and `write` are never high in the same cycle.

## Test plan
- **Single write:** `wr_cmd` with addr=0x100 and len=4, `ready`=1 → `write` high for 4 cycles starting the cycle after `valid`, `burst_count`=4, `addr`=0x100, 4 `wr_data_ack` pulses, one `wr_cmd_ready` pulse.
- **Contention:** both ports request continuously with len=2 after reset → grants alternate W, R, W, R. `read` and `write` never overlap.
- **Credit limit:** eight len=4 reads issued with no read data returned → 8 reads issued, `rd_outstanding`=32, the 9th is held. Return 4 `rddata_valid` beats → the 9th issues. A write requested meanwhile is granted while the read is blocked.
- **Backpressure:** `ready` low for 3 cycles during beat 2 of a len=4 write → `addr`, `burst_count` and `write` stay stable. Exactly 4 acks; IDLE 1 cycle after the 4th.
- **Length clamp:** `cmd_len`=0 → `burst_count`=1. `cmd_len`=20 → `burst_count`=16.
- **Errors and reset:**
  - `rddata_valid` with `rd_outstanding`=0 → `err_rdata` set and stays set.
  - `ddr3_emif_rst_n` low mid-burst → all outputs at their reset values in the same cycle.
